// File: rtl/mlp_pkg.sv
// mlp_pkg: constants and types shared by the MLP layers and the argmax stage.
//   N_CLASS  output-layer width (scores per sample)
//   SCORE_W  signed score width
//   CLS_W    class index width
//   state_e  argmax stage states (ACCUM collecting, HOLD result pending)
//   score_t  signed score type
package mlp_pkg;

  localparam int N_CLASS = 10;
  localparam int SCORE_W = 16;
  localparam int CLS_W   = $clog2(N_CLASS);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  typedef logic signed [SCORE_W-1:0] score_t;

endpackage

// File: rtl/mlp_argmax_stage.sv
// mlp_argmax_stage: streaming argmax over one sample's output-layer scores.
// One score per beat in, one class index per sample out, through a one-entry
// result register so that samples stream back to back without bubbles.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   score beat handshake
//   s_score           signed score of the current class
//   s_last            final score of a sample
//   m_valid/m_ready   result handshake
//   m_class           0-based index of the largest score
//   m_err             frame length mismatch on this result
//   m_score           winning score (only with MLP_ARGMAX_SCORE_OUT_EN defined)
//
// Build option: MLP_ARGMAX_SCORE_OUT_EN adds the m_score output port.
module mlp_argmax_stage #(
  parameter int N_CLASS = mlp_pkg::N_CLASS,
  parameter int SCORE_W = mlp_pkg::SCORE_W,
  parameter int CLS_W   = $clog2(N_CLASS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [SCORE_W-1:0] s_score,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CLS_W-1:0]          m_class,
`ifdef MLP_ARGMAX_SCORE_OUT_EN
  output logic                      m_err,
  output logic signed [SCORE_W-1:0] m_score
`else
  output logic                      m_err
`endif
);

  import mlp_pkg::state_e;
  import mlp_pkg::ACCUM;
  import mlp_pkg::HOLD;

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_CLASS - 1);

  state_e                    r_state, w_state_nxt;
  logic [CLS_W-1:0]          r_idx;
  logic signed [SCORE_W-1:0] r_max;
  logic [CLS_W-1:0]          r_best;
  logic [CLS_W-1:0]          r_class;
  logic                      r_err;

  logic                      w_acc;
  logic                      w_at_end;
  logic                      w_end;
  logic                      w_take;
  logic signed [SCORE_W-1:0] w_new_max;
  logic [CLS_W-1:0]          w_new_best;

  assign w_acc    = s_valid & s_ready;
  assign w_at_end = (r_idx == LAST_IDX);
  assign w_end    = w_acc & (s_last | w_at_end);

  // Beat 0 always loads; later beats only on a strictly greater score so a
  // tie keeps the lower index.
  assign w_take     = (r_idx == '0) || (s_score > r_max);
  assign w_new_max  = w_take ? s_score : r_max;
  assign w_new_best = w_take ? r_idx   : r_best;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  // Next state. A beat accepted in HOLD while the result retires belongs to
  // the next frame; if it also ends that frame we stay in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_end) w_state_nxt = HOLD;
      HOLD:    if (m_ready) w_state_nxt = w_end ? HOLD : ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    s_ready = 1'b1;
    m_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        s_ready = 1'b1;
        m_valid = 1'b0;
      end
      HOLD: begin
        s_ready = m_ready;
        m_valid = 1'b1;
      end
      default: begin
        s_ready = 1'b1;
        m_valid = 1'b0;
      end
    endcase
  end

  // Running argmax over the current frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_max  <= '0;
      r_best <= '0;
    end else if (w_acc) begin
      r_idx  <= w_end ? '0 : r_idx + 1'b1;
      r_max  <= w_new_max;
      r_best <= w_new_best;
    end
  end

  // Result register. Error flags a marker that disagrees with the count:
  // s_last early (short) or missing on the final index (unmarked).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class <= '0;
      r_err   <= 1'b0;
    end else if (w_end) begin
      r_class <= w_new_best;
      r_err   <= s_last ^ w_at_end;
    end
  end

  assign m_class = r_class;
  assign m_err   = r_err;

`ifdef MLP_ARGMAX_SCORE_OUT_EN
  logic signed [SCORE_W-1:0] r_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_score <= '0;
    else if (w_end) r_score <= w_new_max;
  end

  assign m_score = r_score;
`endif

endmodule

// File: tb/tb_mlp_argmax_stage.sv
// Self-checking bench for mlp_argmax_stage: directed table, hand-written
// multi-cycle sequences, and randomized frames against a reference model.
module tb_mlp_argmax_stage;
  import mlp_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      s_valid = 1'b0;
  logic                      s_ready;
  logic signed [SCORE_W-1:0] s_score = '0;
  logic                      s_last = 1'b0;
  logic                      m_valid;
  logic                      m_ready = 1'b0;
  logic [CLS_W-1:0]          m_class;
  logic                      m_err;
`ifdef MLP_ARGMAX_SCORE_OUT_EN
  logic signed [SCORE_W-1:0] m_score;
`endif

  mlp_argmax_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_score (s_score),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_class (m_class),
`ifdef MLP_ARGMAX_SCORE_OUT_EN
    .m_err   (m_err),
    .m_score (m_score)
`else
    .m_err   (m_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int err;
    int score;
  } res_t;

  typedef struct {
    int sc[N_CLASS];
    int len;
    bit marked;
    int cls;
    int err;
    int score;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0: m_ready low, 1: high, 2: random
  res_t rx_q[$];
  int   rx_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    m_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);

  // Capture each completed transfer just before the edge that retires it
  always @(negedge clk) begin
    int msc;
    #4;
    msc = 0;
`ifdef MLP_ARGMAX_SCORE_OUT_EN
    msc = int'(m_score);
`endif
    if (rst_n && m_valid && m_ready) begin
      rx_q.push_back('{int'(m_class), int'(m_err), msc});
      rx_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Argmax by definition: find the maximum value, then the first index
  // holding it. The frame is clean only if it is marked and full length.
  function automatic res_t ref_model(input int sc[N_CLASS], input int len, input bit marked);
    res_t r;
    int mx = sc[0];
    for (int i = 1; i < len; i++) if (sc[i] > mx) mx = sc[i];
    r.cls = -1;
    for (int i = 0; i < len; i++) if (r.cls < 0 && sc[i] == mx) r.cls = i;
    r.err = (marked && len == N_CLASS) ? 0 : 1;
    r.score = mx;
    return r;
  endfunction

  task automatic send_frame(input int sc[N_CLASS], input int len, input bit marked,
                            output int acc_cyc, output int stalls);
    bit ok;
    stalls = 0;
    acc_cyc = 0;
    for (int b = 0; b < len; b++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_score = SCORE_W'(sc[b]);
      s_last  = marked && (b == len - 1);
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        #4;
        if (s_ready) begin
          ok = 1'b1;
          acc_cyc = cyc;
          break;
        end
        stalls++;
        @(negedge clk);
      end
      if (!ok) chk("beat_accept_timeout", 0, 1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int t = 0; t < 3000 && rx_q.size() < n; t++) @(negedge clk);
    if (rx_q.size() < n) chk("result_timeout", rx_q.size(), n);
  endtask

  task automatic cmp_res(input string nm, input res_t exp);
    res_t r;
    if (rx_q.size() == 0) begin
      chk({nm, "_missing"}, 0, 1);
      return;
    end
    r = rx_q.pop_front();
    void'(rx_cyc.pop_front());
    chk({nm, "_class"}, r.cls, exp.cls);
    chk({nm, "_err"}, r.err, exp.err);
`ifdef MLP_ARGMAX_SCORE_OUT_EN
    chk({nm, "_score"}, r.score, exp.score);
`endif
  endtask

  function automatic void rand_frame(output int sc[N_CLASS], output int len, output bit marked);
    int  r = $urandom_range(0, 9);
    bit  narrow = $urandom_range(0, 1) == 1;
    if (r < 7)      begin len = N_CLASS; marked = 1'b1; end
    else if (r < 9) begin len = $urandom_range(1, N_CLASS - 1); marked = 1'b1; end
    else            begin len = N_CLASS; marked = 1'b0; end
    for (int i = 0; i < N_CLASS; i++)
      sc[i] = narrow ? $urandom_range(0, 6) - 3 : $urandom_range(0, 65535) - 32768;
  endfunction

  vec_t tbl[8];

  initial begin
    int   ac, ac1, ac2, st1, st2, n0, len;
    bit   mk;
    int   sc[N_CLASS];
    int   sc2[N_CLASS];
    res_t e1, e2;
    res_t exp_q[$];

    tbl[0] = '{'{3, -1, 7, 2, 7, 0, 0, 0, 0, 5}, 10, 1'b1, 2, 0, 7};
    tbl[1] = '{'{-50, -9, -30, -40, -60, -70, -80, -90, -95, -100}, 10, 1'b1, 1, 0, -9};
    tbl[2] = '{'{1, 2, 9, 4, 3, 99, 99, 99, 99, 99}, 5, 1'b1, 2, 1, 9};
    tbl[3] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 11}, 10, 1'b0, 9, 1, 11};
    tbl[4] = '{'{4, 4, 4, 4, 4, 4, 4, 4, 4, 4}, 10, 1'b1, 0, 0, 4};
    tbl[5] = '{'{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767},
               10, 1'b1, 9, 0, 32767};
    tbl[6] = '{'{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768},
               10, 1'b1, 0, 0, -32768};
    tbl[7] = '{'{5, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b1, 0, 1, 5};

    // Reset state
    @(negedge clk);
    #4;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_class", int'(m_class), 0);
    chk("rst_m_err", int'(m_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("rst_s_ready", int'(s_ready), 1);

    // Directed table
    rdy_mode = 1;
    foreach (tbl[k]) begin
      send_frame(tbl[k].sc, tbl[k].len, tbl[k].marked, ac, st1);
      idle();
      wait_rx(1);
      cmp_res($sformatf("tbl%0d", k), '{tbl[k].cls, tbl[k].err, tbl[k].score});
    end

    // Back-to-back samples with m_ready held high
    rand_frame(sc, len, mk);
    rand_frame(sc2, len, mk);
    e1 = ref_model(sc, N_CLASS, 1'b1);
    e2 = ref_model(sc2, N_CLASS, 1'b1);
    send_frame(sc, N_CLASS, 1'b1, ac1, st1);
    send_frame(sc2, N_CLASS, 1'b1, ac2, st2);
    idle();
    wait_rx(2);
    chk("b2b_stalls", st1 + st2, 0);
    if (rx_cyc.size() >= 2) begin
      chk("b2b_lat1", rx_cyc[0] - ac1, 1);
      chk("b2b_gap", rx_cyc[1] - rx_cyc[0], N_CLASS);
    end
    cmp_res("b2b_a", e1);
    cmp_res("b2b_b", e2);

    // Consumer stall: result held, upstream blocked
    rdy_mode = 0;
    rand_frame(sc, len, mk);
    rand_frame(sc2, len, mk);
    e1 = ref_model(sc, N_CLASS, 1'b1);
    e2 = ref_model(sc2, N_CLASS, 1'b1);
    send_frame(sc, N_CLASS, 1'b1, ac, st1);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #4;
      chk("stall_m_valid", int'(m_valid), 1);
      chk("stall_s_ready", int'(s_ready), 0);
      chk("stall_m_class", int'(m_class), e1.cls);
    end
    rdy_mode = 1;
    send_frame(sc2, N_CLASS, 1'b1, ac, st1);
    idle();
    wait_rx(2);
    cmp_res("stall_a", e1);
    cmp_res("stall_b", e2);

    // Reset mid-frame discards the partial frame
    sc = '{1000, 2000, 3000, 4000, 5000, 6000, 7000, 0, 0, 0};
    send_frame(sc, 7, 1'b0, ac, st1);
    idle();
    n0 = rx_q.size();
    @(negedge clk);
    rst_n = 1'b0;
    #4;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_m_class", int'(m_class), 0);
    chk("midrst_m_err", int'(m_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(tbl[1].sc, N_CLASS, 1'b1, ac, st1);
    idle();
    wait_rx(n0 + 1);
    repeat (3) @(negedge clk);
    chk("midrst_count", rx_q.size(), n0 + 1);
    cmp_res("midrst", '{tbl[1].cls, tbl[1].err, tbl[1].score});

    // Randomized frames with random consumer backpressure
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      rand_frame(sc, len, mk);
      exp_q.push_back(ref_model(sc, len, mk));
      send_frame(sc, len, mk, ac, st1);
    end
    idle();
    wait_rx(40);
    for (int f = 0; f < 40; f++) cmp_res($sformatf("rnd%0d", f), exp_q[f]);

    rdy_mode = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlp_argmax_stage.md
# mlp_argmax_stage

Streaming argmax classifier placed directly downstream of the two-layer MLP datapath (50→20 ReLU→10). It accepts the output-layer scores of one sample, one score per beat, over a valid/ready handshake. It emits the index of the largest score as the predicted class. A one-entry result register decouples it from the consumer, so back-to-back samples stream without bubbles.

## Interface
Parameters:
- N_CLASS, 10, scores per sample (output-layer width); must be ≥ 2
- SCORE_W, 16, width of each signed two's-complement score
- CLS_W, $clog2(N_CLASS), width of class index

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  score beat valid
- s_ready  out  1  stage can accept a beat
- s_score  in  SCORE_W  signed score of current class
- s_last  in  1  marks final score of a sample
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts result
- m_class  out  CLS_W  0-based index of maximum score
- m_err  out  1  frame length mismatch on this result

## Operation
- Beat accepted when s_valid && s_ready; result transferred when m_valid && m_ready.
- Internal: beat counter idx (0..N_CLASS-1), running max max_q (signed), best index best_q.
- States: ACCUM (collecting), HOLD (result pending).
- ACCUM: s_ready=1. Beat at idx 0 loads max_q=s_score, best_q=0. Beat at idx>0 updates only if s_score > max_q (strict signed compare), so ties keep the lowest index. idx increments per beat.
- Frame ends on accepted beat with s_last=1 or idx==N_CLASS-1, whichever comes first. The result is registered into m_class/m_err using that beat's compare outcome. idx clears to 0 and the state moves to HOLD.
- m_err=1 if s_last=1 at idx<N_CLASS-1 (short frame) or s_last=0 at idx==N_CLASS-1 (long/unmarked frame). Otherwise m_err=0. A long frame's excess beats start the next frame.
- HOLD: m_valid=1; m_class/m_err stable until transfer. s_ready = m_ready.
- HOLD with m_ready=1: result retires. Any beat accepted the same cycle is idx 0 of the next frame; state returns to ACCUM. If that beat also ends a frame (N_CLASS=1 is disallowed, but short-frame s_last can), a new result loads and the state stays HOLD.
- Scores are signed. The all-negative case must select the least-negative score.

## Timing
- Reset values: m_valid=0, m_class=0, m_err=0, idx=0, max_q=0, best_q=0, state=ACCUM. s_ready=1 once rst_n deasserts.
- Latency: m_valid rises the cycle after the final beat is accepted.
- Throughput: one score per cycle sustained with m_ready held high. A sample every N_CLASS cycles, no bubble.
- s_ready is combinational from state and m_ready. There are no other combinational input→output paths.
- Reset mid-frame discards the partial frame and any pending result. No output is produced for it.
- m_ready low in HOLD stalls the upstream stage (s_ready=0) indefinitely with no data loss.

## Configuration
- MLP_ARGMAX_SCORE_OUT_EN defined: adds output port m_score (SCORE_W, signed). It carries the winning score, is registered with m_class, and resets to 0.
- Undefined: the m_score port is absent. max_q remains internal only.

## Structure
- Shared package mlp_pkg: N_CLASS, SCORE_W, CLS_W constants, state enum (ACCUM, HOLD), and the signed score typedef. The upstream MLP layers reuse this package.
- No sub-module. The compare/select is a single expression in this module.

## Test plan
- Scores 3,−1,7,2,7,0,0,0,0,5 with s_last on beat 9 → m_class=2, m_err=0 (tie at 4 loses); with macro defined, m_score=7.
- All scores negative (−50,−9,−30,…,−100) → m_class=1.
- Two samples back-to-back, m_ready=1 throughout → results 1 and 10 cycles after the first frame's last beat; s_ready never drops.
- m_ready held 0 for 5 cycles after a result → s_ready=0, m_class stable; on release the next frame proceeds and the following result is correct.
- s_last on beat 4 (short frame) → m_err=1, m_class is the argmax of beats 0–4. No s_last on beat 9 → m_err=1.
- rst_n pulsed low after beat 6 → outputs at reset values; the next full frame yields its correct class with no residue.
